button_events: RTL and testbench

- Input conditioner for the active-low board buttons (UPduino gpio_2/46/47 after SB_IO pull-up input).
- Converts raw asynchronous button levels into clean, clk-domain events for the main design:
  - a debounced "pressed" level
  - single-cycle press, release, long-press and auto-repeat pulses.
- Sits between the top-level input buffers and the main module, one independent channel per button.

---
 rtl/button_events.sv | 159 +++++++++++++++
 tb/tb_button_events.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_events.sv
// Debounce and event generation for active-low board buttons.
// Per channel: 2-flop synchronizer, debounce FSM, press/release/long/repeat pulses.
module button_events #(
    parameter int unsigned NUM_BUTTONS     = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 120_000,
    parameter int unsigned LONG_CYCLES     = 6_000_000,
    parameter int unsigned REPEAT_CYCLES   = 1_200_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button_n_i,
    output logic [NUM_BUTTONS-1:0] pressed_o,
    output logic [NUM_BUTTONS-1:0] press_o,
    output logic [NUM_BUTTONS-1:0] release_o,
    output logic [NUM_BUTTONS-1:0] long_o,
    output logic [NUM_BUTTONS-1:0] repeat_o
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int unsigned REP_W  = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam bit          REP_EN = (REPEAT_CYCLES > 0);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    localparam logic [1:0] UP       = 2'd0;
    localparam logic [1:0] DEB_DOWN = 2'd1;
    localparam logic [1:0] DOWN     = 2'd2;
    localparam logic [1:0] DEB_UP   = 2'd3;

    logic [NUM_BUTTONS-1:0] sync1_n;
    logic [NUM_BUTTONS-1:0] sync_n;

    // Two-flop synchronizer; resets to the released level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_n <= '1;
            sync_n  <= '1;
        end else begin
            sync1_n <= button_n_i;
            sync_n  <= sync1_n;
        end
    end

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
        logic [1:0]        state, state_next;
        logic [DEB_W-1:0]  deb_cnt, deb_next;
        logic [HOLD_W-1:0] hold_cnt, hold_next;
        logic [REP_W-1:0]  rep_cnt, rep_next;
        logic              long_done, long_done_next;
        logic              pressed_q, pressed_next;
        logic              press_q, press_next;
        logic              release_q, release_next;
        logic              long_q, long_next;
        logic              repeat_q, repeat_next;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state     <= UP;
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                rep_cnt   <= '0;
                long_done <= 1'b0;
                pressed_q <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state     <= state_next;
                deb_cnt   <= deb_next;
                hold_cnt  <= hold_next;
                rep_cnt   <= rep_next;
                long_done <= long_done_next;
                pressed_q <= pressed_next;
                press_q   <= press_next;
                release_q <= release_next;
                long_q    <= long_next;
                repeat_q  <= repeat_next;
            end
        end

        // Hold and repeat counters freeze (not clear) while a release is being debounced
        always_comb begin
            state_next     = state;
            deb_next       = deb_cnt;
            hold_next      = hold_cnt;
            rep_next       = rep_cnt;
            long_done_next = long_done;
            pressed_next   = pressed_q;
            press_next     = 1'b0;
            release_next   = 1'b0;
            long_next      = 1'b0;
            repeat_next    = 1'b0;
            case (state)
                UP: begin
                    if (!sync_n[g]) begin
                        state_next = DEB_DOWN;
                        deb_next   = '0;
                    end
                end
                DEB_DOWN: begin
                    if (sync_n[g]) begin
                        state_next = UP;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_next     = DOWN;
                        press_next     = 1'b1;
                        pressed_next   = 1'b1;
                        hold_next      = '0;
                        long_done_next = 1'b0;
                    end else begin
                        deb_next = deb_cnt + DEB_W'(1);
                    end
                end
                DOWN: begin
                    if (sync_n[g]) begin
                        state_next = DEB_UP;
                        deb_next   = '0;
                    end else if (!long_done) begin
                        hold_next = hold_cnt + HOLD_W'(1);
                        if (hold_cnt == HOLD_LAST) begin
                            long_next      = 1'b1;
                            long_done_next = 1'b1;
                            rep_next       = '0;
                        end
                    end else if (REP_EN) begin
                        if (rep_cnt == REP_LAST) begin
                            repeat_next = 1'b1;
                            rep_next    = '0;
                        end else begin
                            rep_next = rep_cnt + REP_W'(1);
                        end
                    end
                end
                DEB_UP: begin
                    if (!sync_n[g]) begin
                        state_next = DOWN;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_next   = UP;
                        release_next = 1'b1;
                        pressed_next = 1'b0;
                    end else begin
                        deb_next = deb_cnt + DEB_W'(1);
                    end
                end
                default: state_next = UP;
            endcase
        end

        assign pressed_o[g] = pressed_q;
        assign press_o[g]   = press_q;
        assign release_o[g] = release_q;
        assign long_o[g]    = long_q;
        assign repeat_o[g]  = repeat_q;
    end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: debounce latency, glitch rejection, long/repeat timing,
// simultaneous channels, reset mid-hold, and a repeat-disabled build.
module tb_button_events;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] btn;
    logic [2:0] btn0;
    logic [2:0] pressed, press, rel, lng, rep;
    logic [2:0] pressed0, press0, rel0, lng0, rep0;

    int errors = 0;
    int checks = 0;
    int n_press [3];
    int n_rel   [3];
    int n_long  [3];
    int n_rep   [3];
    int n_both;
    int n_long0;
    int n_rep0;

    always #5 clk = ~clk;

    button_events #(.NUM_BUTTONS(3), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .button_n_i(btn),
        .pressed_o(pressed), .press_o(press), .release_o(rel), .long_o(lng), .repeat_o(rep)
    );

    button_events #(.NUM_BUTTONS(3), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .button_n_i(btn0),
        .pressed_o(pressed0), .press_o(press0), .release_o(rel0), .long_o(lng0), .repeat_o(rep0)
    );

    initial begin
        for (int i = 0; i < 3; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; n_rep[i] = 0;
        end
        n_both = 0; n_long0 = 0; n_rep0 = 0;
    end

    // Pulse tallies, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                if (press[i]) n_press[i]++;
                if (rel[i])   n_rel[i]++;
                if (lng[i])   n_long[i]++;
                if (rep[i])   n_rep[i]++;
                if (press[i] && rel[i]) n_both++;
            end
            n_long0 = n_long0 + int'(lng0[0]) + int'(lng0[1]) + int'(lng0[2]);
            n_rep0  = n_rep0 + int'(rep0[0]) + int'(rep0[1]) + int'(rep0[2]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        btn   = 3'b111;
        btn0  = 3'b111;
        tick(2);
        chk("reset_outputs", 32'({pressed, press, rel, lng, rep}), 32'd0);
        reset = 1'b0;
        tick(3);
        chk("idle_pressed", 32'(pressed), 32'd0);

        // Clean press on channel 0
        btn = 3'b110;
        tick(6);
        chk("clean_press_early", 32'(press), 32'd0);
        tick(1);
        chk("clean_press", 32'(press), 32'b001);
        chk("clean_pressed", 32'(pressed), 32'b001);
        tick(1);
        chk("clean_press_width", 32'(press), 32'd0);
        tick(2);
        btn = 3'b111;
        tick(6);
        chk("clean_rel_early", 32'({pressed, rel}), 32'b001_000);
        tick(1);
        chk("clean_rel", 32'({pressed, rel}), 32'b000_001);
        tick(1);
        chk("clean_rel_width", 32'(rel), 32'd0);
        tick(3);

        // Short glitch on channel 1
        btn = 3'b101;
        tick(3);
        btn = 3'b111;
        tick(10);
        chk("glitch_pressed", 32'(pressed), 32'd0);
        chk("glitch_no_press", 32'(n_press[1]), 32'd0);

        // Release bounce on channel 1
        btn = 3'b101;
        tick(7);
        chk("bounce_press", 32'(press), 32'b010);
        tick(2);
        btn = 3'b111;
        tick(2);
        btn = 3'b101;
        tick(10);
        chk("bounce_pressed", 32'(pressed), 32'b010);
        chk("bounce_no_rel", 32'(n_rel[1]), 32'd0);
        btn = 3'b111;
        tick(7);
        chk("bounce_rel", 32'(rel), 32'b010);
        tick(3);

        // Long press and auto-repeat on channel 2
        btn = 3'b011;
        tick(7);
        chk("long_press", 32'(press), 32'b100);
        tick(19);
        chk("long_early", 32'(lng), 32'd0);
        tick(1);
        chk("long_fire", 32'(lng), 32'b100);
        for (int r = 0; r < 4; r++) begin
            tick(7);
            chk("repeat_early", 32'(rep), 32'd0);
            tick(1);
            chk("repeat_fire", 32'(rep), 32'b100);
        end
        tick(1);
        btn = 3'b111;
        tick(7);
        chk("long_rel", 32'({pressed, rel}), 32'b000_100);
        tick(3);

        // All three pressed together, released staggered
        btn = 3'b000;
        tick(7);
        chk("simul_press", 32'(press), 32'b111);
        tick(3);
        btn = 3'b001;
        tick(2);
        btn = 3'b011;
        tick(2);
        btn = 3'b111;
        tick(3);
        chk("stagger_rel0", 32'(rel), 32'b001);
        tick(2);
        chk("stagger_rel1", 32'(rel), 32'b010);
        tick(2);
        chk("stagger_rel2", 32'(rel), 32'b100);
        tick(3);

        // Reset while channel 0 is held
        btn = 3'b110;
        tick(7);
        chk("rst_press", 32'(press), 32'b001);
        tick(3);
        chk("rst_pre_pressed", 32'(pressed), 32'b001);
        reset = 1'b1;
        #1;
        chk("rst_async_clear", 32'({pressed, press, rel, lng, rep}), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(6);
        chk("rst_repress_early", 32'(press), 32'd0);
        tick(1);
        chk("rst_repress", 32'({pressed, press}), 32'b001_001);
        btn = 3'b111;
        tick(7);
        chk("rst_rel", 32'(rel), 32'b001);
        tick(3);

        // Repeat-disabled build: one long pulse, no repeats
        btn0 = 3'b110;
        tick(7);
        chk("norep_press", 32'(press0), 32'b001);
        tick(20);
        chk("norep_long", 32'(lng0), 32'b001);
        tick(33);
        btn0 = 3'b111;
        tick(10);
        chk("norep_long_count", 32'(n_long0), 32'd1);
        chk("norep_rep_count", 32'(n_rep0), 32'd0);
        chk("norep_released", 32'(pressed0), 32'd0);

        // Whole-run pulse tallies for the main instance
        chk("cnt_press0", 32'(n_press[0]), 32'd4);
        chk("cnt_press1", 32'(n_press[1]), 32'd2);
        chk("cnt_press2", 32'(n_press[2]), 32'd2);
        chk("cnt_rel0", 32'(n_rel[0]), 32'd3);
        chk("cnt_rel1", 32'(n_rel[1]), 32'd2);
        chk("cnt_rel2", 32'(n_rel[2]), 32'd2);
        chk("cnt_long", 32'({n_long[2][7:0], n_long[1][7:0], n_long[0][7:0]}), 32'h010000);
        chk("cnt_rep", 32'({n_rep[2][7:0], n_rep[1][7:0], n_rep[0][7:0]}), 32'h040000);
        chk("cnt_press_rel_same", 32'(n_both), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
